io_port_bridge: RTL

- Device-side end of the processor's IN/OUT port protocol. Sits between the core's IO unit and an external peripheral.
- OUT path: the word presented for OUT (the R[31] value) is pushed into a TX FIFO, then drained to the device over a valid/ready handshake.
- IN path: the device pushes words over valid/ready into an RX FIFO. The IO unit takes them as in_data on IN.
- Back-pressure to the core is a stall signal.

---
 rtl/io_pkg.sv | 11 +
 rtl/io_sync_fifo.sv | 63 ++++++
 rtl/io_port_bridge.sv | 75 +++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared opcodes and word type for the IO port bridge.
package io_pkg;

  localparam int unsigned IO_DATA_W = 32;

  localparam logic [5:0] OP_OUT = 6'b111101;
  localparam logic [5:0] OP_IN  = 6'b111110;

  typedef logic [IO_DATA_W-1:0] word_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Show-ahead synchronous FIFO with a separately tracked occupancy count.
// Callers never push when full or pop when empty.
module io_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // Stale storage is never exposed: an empty FIFO reads as zero.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state pointers and count; pointers wrap naturally modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/io_port_bridge.sv
// Device-side end of the IN/OUT port protocol: opcode decode, core stall and
// valid/ready glue around one TX and one RX FIFO.
module io_port_bridge
  import io_pkg::*;
#(
  parameter int unsigned DATA_W = IO_DATA_W,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        control_signal,
  input  logic [DATA_W-1:0] cpu_out_data,
  output logic [DATA_W-1:0] cpu_in_data,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] ext_tx_data,
  output logic              ext_tx_valid,
  input  logic              ext_tx_ready,
  input  logic [DATA_W-1:0] ext_rx_data,
  input  logic              ext_rx_valid,
  output logic              ext_rx_ready,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count
);

  logic is_out, is_in;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;

  // Opcode decode, stall and handshake glue. Full/empty are the registered
  // flags, so a same-cycle pop never makes room for a core push and a
  // same-cycle device push is never visible to an IN.
  always_comb begin
    is_out       = (control_signal == OP_OUT);
    is_in        = (control_signal == OP_IN);
    tx_push      = is_out && !tx_full;
    rx_pop       = is_in && !rx_empty;
    cpu_stall    = (is_out && tx_full) || (is_in && rx_empty);
    ext_tx_valid = !tx_empty;
    tx_pop       = ext_tx_valid && ext_tx_ready;
    ext_rx_ready = !rx_full && !rst;
    rx_push      = ext_rx_valid && ext_rx_ready;
  end

  io_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (cpu_out_data),
    .rdata (ext_tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  io_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (ext_rx_data),
    .rdata (cpu_in_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

endmodule
